// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 60-bit processor core: sequencer
//               state encoding, opcode class boundaries, instruction field
//               geometry and the opcode class-decode helpers used by both the
//               instruction sequencer and the control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Instruction geometry: the opcode sits in the top OPC_W bits.
    localparam int CPU_INSTR_W = 60;
    localparam int OPC_W       = 4;
    localparam int OPC_MSB     = CPU_INSTR_W - 1;

    // Sequencer state encoding (exposed on the debug state port).
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    // Opcode classes.
    localparam logic [OPC_W-1:0] OP_HALT     = 4'd0;
    localparam logic [OPC_W-1:0] OP_R_FIRST  = 4'd1;
    localparam logic [OPC_W-1:0] OP_R_LAST   = 4'd8;
    localparam logic [OPC_W-1:0] OP_I_FIRST  = 4'd9;
    localparam logic [OPC_W-1:0] OP_I_LAST   = 4'd11;
    localparam logic [OPC_W-1:0] OP_BR_FIRST = 4'd12;

    function automatic logic is_rtype(input logic [OPC_W-1:0] op);
        return (op >= OP_R_FIRST) && (op <= OP_R_LAST);
    endfunction

    function automatic logic is_itype(input logic [OPC_W-1:0] op);
        return (op >= OP_I_FIRST) && (op <= OP_I_LAST);
    endfunction

    // Branches occupy the top of the opcode space (12..15).
    function automatic logic is_branch(input logic [OPC_W-1:0] op);
        return (op >= OP_BR_FIRST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle fetch/decode/execute/writeback sequencer. Owns the
//               PC and instruction register, handshakes with instruction
//               memory and the ALU, and sequences register-file writes and PC
//               updates (including taken branches). One instruction in
//               flight at a time.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               imem_req/addr/valid/instr - instruction fetch handshake
//               opcode                    - IR opcode to control decoder
//               alu_start/done, branch_taken - ALU launch / completion
//               reg_we                    - register-file write strobe
//               pc, halted, state         - status / debug
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                INSTR_W = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic [OPC_W-1:0]   opcode,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic               branch_taken,
    output logic               reg_we,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [2:0]         state
);

    localparam logic [ADDR_W-1:0] c_pc_one = 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [INSTR_W-1:0]  r_ir;
    logic [INSTR_W-1:0]  w_ir_next;
    // Set once the ALU launch pulse has been issued for the current EXEC
    // visit; alu_done is only honoured while this is set.
    logic                r_launched;
    logic                w_launched_next;
    logic [OPC_W-1:0]    w_opcode;
    logic                w_unused_ir_bits;

    assign w_opcode  = r_ir[INSTR_W-1 -: OPC_W];
    assign opcode    = w_opcode;
    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign state     = r_state;

    // IR bits between the branch target field and the opcode belong to the
    // decoder/register file; the sequencer itself never looks at them.
    assign w_unused_ir_bits = ^r_ir[INSTR_W-OPC_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RST_PC;
            r_ir       <= '0;
            r_launched <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_launched <= w_launched_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_launched_next = r_launched;
        // Strobes are forced low while rst is held so that an aborted
        // operation never emits a stray pulse during reset.
        imem_req        = 1'b0;
        alu_start       = 1'b0;
        reg_we          = 1'b0;
        halted          = 1'b0;

        case (r_state)
            FETCH: begin
                imem_req = !rst;
                // A valid in the very cycle the request rises is accepted.
                if (imem_valid) begin
                    w_ir_next    = imem_instr;
                    w_state_next = DECODE;
                end
            end

            DECODE: begin
                // Single cycle covering the control decoder's register stage.
                w_state_next = (w_opcode == OP_HALT) ? HALT : EXEC;
            end

            EXEC: begin
                if (!r_launched) begin
                    alu_start       = !rst;
                    w_launched_next = 1'b1;
                end else if (alu_done) begin
                    w_launched_next = 1'b0;
                    if (is_branch(w_opcode)) begin
                        w_pc_next    = branch_taken ? r_ir[ADDR_W-1:0]
                                                    : r_pc + c_pc_one;
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = WB;
                    end
                end
            end

            WB: begin
                reg_we       = !rst;
                w_pc_next    = r_pc + c_pc_one;
                w_state_next = FETCH;
            end

            HALT: begin
                // Sticky; pc stays at the halt instruction's address.
                halted = !rst;
            end

            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback sequencer for the 60-bit processor core.
- Owns the PC and instruction register (IR).
- Handshakes with instruction memory and the ALU.
- Presents the opcode to the registered control decoder and sequences register-file writes and PC updates, including taken branches.
- Sits between imem, the control decoder, the ALU and the register file.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 60, instruction width; opcode is IR[INSTR_W-1 -: 4]
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held high until imem_valid
imem_addr  out  ADDR_W  fetch address (= pc)
imem_valid  in  1  imem_instr valid this cycle; ignored unless imem_req=1
imem_instr  in  INSTR_W  fetched instruction
opcode  out  4  IR opcode field to control decoder
alu_start  out  1  one-cycle ALU launch pulse
alu_done  in  1  ALU result/compare ready
branch_taken  in  1  ALU compare outcome, sampled with alu_done
reg_we  out  1  one-cycle register-file write pulse
pc  out  ADDR_W  current PC
halted  out  1  sequencer stopped on opcode 0
state  out  3  current FSM state encoding, for debug/verification

Behaviour:
- Reset values: state=FETCH, pc=RST_PC, IR=0, imem_req=0, alu_start=0, reg_we=0, halted=0, opcode=0.
- A reset asserted mid-operation aborts any outstanding fetch or ALU operation. A late imem_valid or alu_done arriving after reset is ignored.

States:
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: IR<=imem_instr, imem_req drops next cycle, go to DECODE.
  - imem_valid in the same cycle imem_req first rises is accepted (minimum 1-cycle fetch).
- DECODE:
  - Exactly 1 cycle, which covers the control decoder's register stage.
  - Opcode 0 -> HALT.
  - Opcodes 1-15 -> EXEC.
- EXEC:
  - alu_start=1 for the first EXEC cycle only.
  - Then wait for alu_done; alu_done is sampled only from the cycle after alu_start.
  - Opcodes 1-11 (R-type 1-8, I-type 9-11) -> WB.
  - Opcodes 12-15 (branch): on alu_done, pc <= branch_taken ? IR[ADDR_W-1:0] : pc+1, then go to FETCH. No reg_we.
- WB:
  - reg_we=1 for exactly 1 cycle, pc<=pc+1, go to FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Sticky until rst; pc is frozen at the HALT instruction's address.

Rules:
- opcode output = IR opcode field, stable from DECODE through the end of the instruction.
- pc+1 wraps modulo 2^ADDR_W (all-ones -> 0). A branch target equal to pc is legal (tight loop).
- alu_done and imem_valid are ignored outside EXEC and FETCH respectively.
- alu_start and reg_we never assert in the same cycle.
- At most one instruction is in flight; there is no overlap.
- Latency: R/I instruction = fetch latency + 1 (DECODE) + 1 (EXEC launch) + ALU wait + 1 (WB); 5 cycles minimum with 1-cycle memory and ALU. Branch: 4 cycles minimum.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4
  - opcode class constants: OP_HALT=0, R range 1-8, I range 9-11, BR range 12-15
  - INSTR_W and opcode field position
- The class-decode helper function (is_rtype/is_itype/is_branch) lives in the package so the control decoder and the sequencer agree.
- No sub-module; a single FSM plus PC/IR registers.

Test Plan:
- R-type, 1-cycle memory/ALU: rst then release, imem returns opcode 3 with valid same cycle, alu_done 1 cycle after start. Expect reg_we pulse in cycle 5, pc 0->1, back in FETCH cycle 6.
- I-type with slow memory/ALU: imem_valid after 4 cycles, opcode 10, alu_done 3 cycles after start. Expect imem_req held 4 cycles, exactly one alu_start, exactly one reg_we, pc=1.
- Branch taken then not taken: opcode 13, IR[15:0]=0x0040, branch_taken=1 -> pc=0x0040, no reg_we. Repeat with branch_taken=0 -> pc=0x0041.
- PC wrap: pc=0xFFFF, R-type -> pc=0x0000 and next imem_addr=0x0000.
- Halt: opcode 0 -> halted=1 from the cycle after DECODE. imem_req, alu_start and reg_we stay 0 for 20 cycles; pc unchanged.
- Reset mid-EXEC: assert rst while waiting on alu_done, then pulse alu_done after release. Expect state=FETCH, pc=RST_PC, no reg_we, stray alu_done ignored.
